mem_port_arbiter: RTL

- Sequencer and arbiter placed in front of one shared single-port 16-bit-word memory instance.
- Serves two requesters:
  - data port (requester D, priority)
  - fetch port (requester F)
- Splits 32-bit accesses into two 16-bit beats.
- Returns registered read data and a one-cycle ack.
- Bounds fetch starvation with a counter.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Sequencer/arbiter in front of one shared single-port memory
//             with 16-bit words. Two requesters: data port D (priority) and
//             fetch port F. A 32-bit access is split into two 16-bit beats.
//             Read data is registered and each completion gives a one-cycle
//             ack. A counter bounds how long F can be starved by D.
//  Ports    : clk, reset (async, active-low)
//             d_req/d_wr/d_dbl/d_addr/d_wdata -> d_ack/d_rdata   (data port)
//             f_req/f_wr/f_dbl/f_addr/f_wdata -> f_ack/f_rdata   (fetch port)
//             mem_address/mem_data_in/mem_read/mem_write -> memory
//             mem_data_out <- memory (combinational read data)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic        d_dbl,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic        f_req,
    input  logic        f_wr,
    input  logic        f_dbl,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_wdata,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    output logic [31:0] mem_address,
    output logic [15:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [15:0] mem_data_out
);

    localparam logic [0:0] c_ST_IDLE     = 1'b0;  // arbitrate / first beat
    localparam logic [0:0] c_ST_HI       = 1'b1;  // second beat of 32-bit access
    localparam logic       c_OWN_D       = 1'b0;
    localparam logic       c_OWN_F       = 1'b1;
    localparam logic [3:0] c_MAX_STARVE  = 4'(MAX_STARVE);

    logic [0:0]  r_state;
    logic        r_owner;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [3:0]  r_starve;
    logic        r_d_ack;
    logic        r_f_ack;
    logic [31:0] r_d_rdata;
    logic [31:0] r_f_rdata;

    logic        w_d_req_m;
    logic        w_f_req_m;
    logic        w_starved;
    logic        w_grant_d;
    logic        w_grant_f;
    logic [31:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_rd_en;
    logic        w_wr_en;

    // A requester being acked this cycle is still holding its old request;
    // mask it so the same transaction is not granted twice.
    assign w_d_req_m = d_req & ~r_d_ack;
    assign w_f_req_m = f_req & ~r_f_ack;
    assign w_starved = (r_starve == c_MAX_STARVE);

    assign w_grant_d = (r_state == c_ST_IDLE) & w_d_req_m & (~w_f_req_m | ~w_starved);
    assign w_grant_f = (r_state == c_ST_IDLE) & w_f_req_m & (~w_d_req_m | w_starved);

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        if (r_state == c_ST_HI) begin
            w_addr  = r_addr + 32'd1;  // wraps naturally at 32 bits
            w_rd_en = ~r_wr;
            w_wr_en = r_wr;
            w_wdata = (r_owner == c_OWN_F) ? f_wdata[31:16] : d_wdata[31:16];
        end else if (w_grant_d) begin
            w_addr  = d_addr;
            w_rd_en = ~d_wr;
            w_wr_en = d_wr;
            w_wdata = d_wdata[15:0];
        end else if (w_grant_f) begin
            w_addr  = f_addr;
            w_rd_en = ~f_wr;
            w_wr_en = f_wr;
            w_wdata = f_wdata[15:0];
        end
    end

    // Enables gated by reset so an aborted beat stops writing immediately.
    assign mem_address = w_addr;
    assign mem_data_in = w_wdata;
    assign mem_read    = w_rd_en & reset;
    assign mem_write   = w_wr_en & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_owner   <= c_OWN_D;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_d_ack   <= 1'b0;
            r_f_ack   <= 1'b0;
            r_d_rdata <= '0;
            r_f_rdata <= '0;
        end else begin
            r_d_ack <= 1'b0;
            r_f_ack <= 1'b0;
            if (r_state == c_ST_HI) begin
                if (!r_wr) begin
                    if (r_owner == c_OWN_F) r_f_rdata[31:16] <= mem_data_out;
                    else                    r_d_rdata[31:16] <= mem_data_out;
                end
                if (r_owner == c_OWN_F) r_f_ack <= 1'b1;
                else                    r_d_ack <= 1'b1;
                r_state <= c_ST_IDLE;
            end else if (w_grant_d) begin
                if (!d_wr) begin
                    r_d_rdata[15:0] <= mem_data_out;
                    if (!d_dbl) r_d_rdata[31:16] <= '0;
                end
                if (d_dbl) begin
                    r_state <= c_ST_HI;
                    r_owner <= c_OWN_D;
                    r_addr  <= d_addr;
                    r_wr    <= d_wr;
                end else begin
                    r_d_ack <= 1'b1;
                end
            end else if (w_grant_f) begin
                if (!f_wr) begin
                    r_f_rdata[15:0] <= mem_data_out;
                    if (!f_dbl) r_f_rdata[31:16] <= '0;
                end
                if (f_dbl) begin
                    r_state <= c_ST_HI;
                    r_owner <= c_OWN_F;
                    r_addr  <= f_addr;
                    r_wr    <= f_wr;
                end else begin
                    r_f_ack <= 1'b1;
                end
            end
        end
    end

    // Starvation counter: counts D wins while F is waiting (uses raw f_req,
    // so a masked-but-held F request still counts as waiting).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (!f_req || w_grant_f) begin
            r_starve <= '0;
        end else if (w_grant_d && !w_starved) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    assign d_ack   = r_d_ack;
    assign f_ack   = r_f_ack;
    assign d_rdata = r_d_rdata;
    assign f_rdata = r_f_rdata;

endmodule
`default_nettype wire
